stable_matching_verifier: RTL and testbench
===========================================

// Module: stable_matching_verifier
// PURPOSE
// - Sequential stability checker that consumes the packed preferences and matching of the stable_matching_comb family.
// - Latches one problem (preferences + matching) on start and checks every (A member, B member) pair for a blocking pair.
// - Scans one list entry per cycle, then reports stable / first blocking pair / duplicate-partner error.
// - Sits downstream of the matching core as its self-check or result consumer.
// PARAMETERS
// - Kr   10  preferences per list-B member (receiver)
// - Ks   10  preferences per list-A member (proposer)
// - S    10  members in list A
// - R    10  members in list B
// - logS = $clog2(S), logR = $clog2(R): derived localparams, not overridable
// PORTS
// - clk      in   1                     clock, rising edge
// - rst_n    in   1                     asynchronous, active-low reset
// - start    in   1                     begin a check; sampled only in IDLE
// - p_input  in   R*Kr*logS+S*Ks*logR   A prefs at [(s*Ks+k)*logR +: logR]; B prefs at S*Ks*logR+[(r*Kr+j)*logS +: logS]
// - m_in     in   R*logS+1              partner of r at [r*logS +: logS]; bit R*logS = matching valid
// - busy     out  1                     check in progress
// - done     out  1                     one-cycle pulse, results valid from this cycle
// - stable   out  1                     1 = valid matching, no blocking pair, no duplicate
// - err_dup  out  1                     some A member is partner of two receivers
// - bp_s     out  logS                  first blocking pair: A index
// - bp_r     out  logR                  first blocking pair: B index
// - bp_cnt   out  logS+logR+1           number of blocking pairs (saturating)
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; all outputs 0. Reset mid-check aborts with no done pulse.
// - Encoding: preference entry >= R (A list) or >= S (B list) is padding, ignored. Partner code >= S = receiver unmatched.
// - Cycle t: start=1 in IDLE -> p_input and m_in latched; busy=1 from t+1. start while busy ignored.
// - FSM: IDLE -> CHK -> INV -> SCAN_A <-> SCAN_B -> DONE -> IDLE.
// - CHK (1 cycle): if m_in valid bit = 0 -> DONE with stable=0, err_dup=0, bp_cnt=0.
// - INV (R cycles): r=0..R-1 builds partA[s]=r. Writing an s that is already set -> err_dup=1 -> DONE (stable=0).
// - SCAN_A: one cycle per entry k of A member s, giving r=prefA[s][k]. Padding -> next k.
//   If r==partA[s] -> next s (later entries ranked lower). Otherwise -> SCAN_B.
// - SCAN_B: one cycle per entry j of prefB[r], searching for s and partB[r]. s found first -> blocking pair (s,r).
//   If r is unmatched, finding s is enough. partner found first, or s absent -> no block. Then next k.
// - Blocking pair: bp_cnt increments (saturates at all-ones). The first pair found is latched into bp_s/bp_r.
// - After s=S-1, k=Ks-1 -> DONE. stable = (bp_cnt==0) & ~err_dup.
// - DONE (1 cycle): done=1; busy drops in the same cycle; results hold until the next start is accepted.
// - Worst-case latency from start to done: 2 + R + S*Ks*(1+Kr) cycles.
// - start can be accepted in the IDLE cycle right after the done pulse (back-to-back).
// CONFIGURATION
// - Macro STABLE_VERIF_EARLY_EXIT_EN.
//   Defined: the first blocking pair moves the FSM straight to DONE; bp_cnt is 0 or 1.
//   Undefined: the full scan always runs; bp_cnt counts every blocking pair. Pair order is s ascending, then k ascending.
// STRUCTURE
// - Package stable_matching_pkg holds:
//   - state enum (IDLE, CHK, INV, SCAN_A, SCAN_B, DONE);
//   - field-offset functions for the p_input/m_in layouts (shared with the stable_matching_comb testbenches).
// - Sub-module stable_matching_rank_scan: the SCAN_B engine.
//   Inputs: target s, partner, list r. Outputs: block/no-block with a done strobe.
// - Top level holds the latches, the partA table, the counters and the FSM.
// TESTING (S=R=Ks=Kr=2; A0,A1 prefs [0,1]; B0 prefs [1,0]; B1 prefs [0,1])
// - m: r0->1, r1->0, valid=1 -> done; stable=1, err_dup=0, bp_cnt=0.
// - m: r0->0, r1->1 -> stable=0, bp_s=1, bp_r=0, bp_cnt=1.
// - m: r0->0, r1->0 -> err_dup=1, stable=0; done 4 cycles after start (CHK + 2 INV + DONE).
// - m_in valid bit=0 -> done exactly 2 cycles after start; stable=0, bp_cnt=0.
// - Assert rst_n=0 while in SCAN_B -> outputs 0 immediately, no done pulse. Then a new start gives a correct result.
// - Two back-to-back starts on the valid and the blocking matchings -> both results correct.
//   Repeat the whole suite with and without STABLE_VERIF_EARLY_EXIT_EN.

Source files
------------

// File: rtl/stable_matching_pkg.sv
// stable_matching_pkg: shared FSM state type and p_input/m_in field-offset helpers
package stable_matching_pkg;

    typedef enum logic [2:0] {IDLE, CHK, INV, SCAN_A, SCAN_B, DONE} state_t;

    // bit offset of A member s, entry k inside p_input
    function automatic int a_off(input int s, input int k, input int ks, input int lr);
        return (s * ks + k) * lr;
    endfunction

    // bit offset of B member r, entry j inside p_input; base = S*Ks*logR
    function automatic int b_off(input int r, input int j, input int kr, input int ls, input int base);
        return base + (r * kr + j) * ls;
    endfunction

    // bit offset of the partner code of receiver r inside m_in
    function automatic int m_off(input int r, input int ls);
        return r * ls;
    endfunction

endpackage

// File: rtl/stable_matching_rank_scan.sv
// stable_matching_rank_scan: walks one B preference list, one entry per cycle,
// deciding whether target s is ranked above the current partner.
// Ports: clk, rst_n; en (scan active); target, partner (codes >= S = unmatched);
//        list (Kr packed entries of the receiver); fin (decision strobe); block (target wins).
module stable_matching_rank_scan #(
    parameter int Kr = 10,
    parameter int S  = 10,
    localparam int LS = $clog2(S)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [LS-1:0]    target,
    input  logic [LS-1:0]    partner,
    input  logic [Kr*LS-1:0] list,
    output logic             fin,
    output logic             block
);
    localparam int LJ = Kr > 1 ? $clog2(Kr) : 1;

    logic [LJ-1:0] j;
    logic [LS-1:0] e;
    logic          hit_t, hit_p;

    always_comb begin
        e     = list[int'(j) * LS +: LS];
        hit_t = e == target;
        // padding never matches an unmatched partner code
        hit_p = e == partner && int'(e) < S;
        block = en & hit_t;
        fin   = en & (hit_t | hit_p | int'(j) == Kr - 1);
    end

    // index returns to 0 whenever a decision is made or the scan is idle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) j <= '0;
        else        j <= (en && !fin) ? j + LJ'(1) : '0;

endmodule

// File: rtl/stable_matching_verifier.sv
// stable_matching_verifier: sequential blocking-pair / duplicate-partner checker for a latched matching.
// Ports: clk, rst_n (async, active-low); start; p_input (packed A then B prefs); m_in (partners + valid bit);
//        busy, done (1-cycle pulse), stable, err_dup, bp_s/bp_r (first blocking pair), bp_cnt (saturating).
// Macro STABLE_VERIF_EARLY_EXIT_EN: stop at the first blocking pair instead of counting all of them.
module stable_matching_verifier
    import stable_matching_pkg::*;
#(
    parameter int Kr = 10,
    parameter int Ks = 10,
    parameter int S  = 10,
    parameter int R  = 10,
    localparam int logS = $clog2(S),
    localparam int logR = $clog2(R),
    localparam int PW   = R * Kr * logS + S * Ks * logR,
    localparam int MW   = R * logS + 1,
    localparam int CW   = logS + logR + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PW-1:0]   p_input,
    input  logic [MW-1:0]   m_in,
    output logic            busy,
    output logic            done,
    output logic            stable,
    output logic            err_dup,
    output logic [logS-1:0] bp_s,
    output logic [logR-1:0] bp_r,
    output logic [CW-1:0]   bp_cnt
);
    localparam int LK = Ks > 1 ? $clog2(Ks) : 1;
`ifdef STABLE_VERIF_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    state_t          state, state_n;
    logic [PW-1:0]   p_l;
    logic [MW-1:0]   m_l;
    logic [logR-1:0] part_a [S];
    logic [S-1:0]    set_a;
    logic [logS-1:0] s_i, inv_s, partner;
    logic [LK-1:0]   k_i;
    logic [logR-1:0] r_i, a_r;
    logic            fin_l, inv_ok, inv_dup, a_pad, a_match, last_k, last_s;
    logic            nk, ns, sb_fin, sb_block;

    always_comb begin
        inv_s   = m_l[m_off(int'(r_i), logS) +: logS];
        inv_ok  = int'(inv_s) < S;
        inv_dup = inv_ok && set_a[inv_s];
        a_r     = p_l[a_off(int'(s_i), int'(k_i), Ks, logR) +: logR];
        a_pad   = int'(a_r) >= R;
        a_match = set_a[s_i] && part_a[s_i] == a_r;
        partner = m_l[m_off(int'(a_r), logS) +: logS];
        last_k  = int'(k_i) == Ks - 1;
        last_s  = int'(s_i) == S - 1;
        nk      = (state == SCAN_A && a_pad) || (state == SCAN_B && sb_fin);
        ns      = state == SCAN_A && !a_pad && a_match;
        done    = state == DONE;
        busy    = state inside {CHK, INV, SCAN_A, SCAN_B};
        stable  = fin_l & m_l[MW-1] & ~err_dup & (bp_cnt == '0);
    end

    stable_matching_rank_scan #(.Kr(Kr), .S(S)) u_scan (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state == SCAN_B),
        .target (s_i),
        .partner(partner),
        .list   (p_l[b_off(int'(a_r), 0, Kr, logS, S * Ks * logR) +: Kr * logS]),
        .fin    (sb_fin),
        .block  (sb_block)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   state_n = start ? CHK : IDLE;
            CHK:    state_n = m_l[MW-1] ? INV : DONE;
            INV:    state_n = inv_dup ? DONE : (int'(r_i) == R - 1 ? SCAN_A : INV);
            SCAN_A: state_n = a_pad   ? (last_k && last_s ? DONE : SCAN_A)
                            : a_match ? (last_s ? DONE : SCAN_A) : SCAN_B;
            SCAN_B: state_n = !sb_fin ? SCAN_B
                            : (EARLY && sb_block) || (last_k && last_s) ? DONE : SCAN_A;
            DONE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            p_l     <= '0;
            m_l     <= '0;
            set_a   <= '0;
            s_i     <= '0;
            k_i     <= '0;
            r_i     <= '0;
            fin_l   <= 1'b0;
            err_dup <= 1'b0;
            bp_s    <= '0;
            bp_r    <= '0;
            bp_cnt  <= '0;
        end else begin
            state <= state_n;
            fin_l <= fin_l | (state_n == DONE);
            if (state == IDLE && start) begin
                p_l     <= p_input;
                m_l     <= m_in;
                set_a   <= '0;
                s_i     <= '0;
                k_i     <= '0;
                r_i     <= '0;
                fin_l   <= 1'b0;
                err_dup <= 1'b0;
                bp_s    <= '0;
                bp_r    <= '0;
                bp_cnt  <= '0;
            end
            if (state == INV) begin
                r_i <= r_i + logR'(1);
                if (inv_dup) err_dup <= 1'b1;
                else if (inv_ok) set_a[inv_s] <= 1'b1;
            end
            if (ns || (nk && last_k)) begin
                s_i <= s_i + logS'(1);
                k_i <= '0;
            end else if (nk) begin
                k_i <= k_i + LK'(1);
            end
            if (state == SCAN_B && sb_block) begin
                bp_cnt <= bp_cnt + CW'(~&bp_cnt);
                if (bp_cnt == '0) begin
                    bp_s <= s_i;
                    bp_r <= a_r;
                end
            end
        end
    end

    // partner table is qualified by set_a, so it needs no reset
    always_ff @(posedge clk)
        if (state == INV && inv_ok && !inv_dup) part_a[inv_s] <= r_i;

endmodule

// File: tb/tb_stable_matching_verifier.sv
// tb_stable_matching_verifier: directed checks on a 2x2 instance of stable_matching_verifier
module tb_stable_matching_verifier;
    localparam int S = 2, R = 2, Ks = 2, Kr = 2;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [7:0] p_input = 8'h9A;
    logic [2:0] m_in = 3'b000;
    logic       busy, done, stable, err_dup, bp_s, bp_r;
    logic [2:0] bp_cnt;
    int         total = 0, bad = 0, lat = 0;

    stable_matching_verifier #(.Kr(Kr), .Ks(Ks), .S(S), .R(R)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .p_input(p_input), .m_in(m_in),
        .busy(busy), .done(done), .stable(stable), .err_dup(err_dup),
        .bp_s(bp_s), .bp_r(bp_r), .bp_cnt(bp_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        lat++;
    endtask

    task automatic run(input logic [2:0] m);
        m_in  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        chk("busy_after_start", 32'(busy), 1);
        while (done !== 1'b1 && lat < 200) step();
        chk("done_seen", 32'(done), 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_stable"}, 32'(stable), 0);
        chk({tag, "_dup"}, 32'(err_dup), 0);
        chk({tag, "_bps"}, 32'(bp_s), 0);
        chk({tag, "_bpr"}, 32'(bp_r), 0);
        chk({tag, "_cnt"}, 32'(bp_cnt), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(3'b101);
        chk("valid_lat", lat, 8);
        chk("valid_stable", 32'(stable), 1);
        chk("valid_dup", 32'(err_dup), 0);
        chk("valid_cnt", 32'(bp_cnt), 0);
        step();
        chk("hold_done_low", 32'(done), 0);
        chk("hold_busy_low", 32'(busy), 0);
        chk("hold_stable", 32'(stable), 1);

        run(3'b110);
`ifdef STABLE_VERIF_EARLY_EXIT_EN
        chk("block_lat", lat, 7);
`else
        chk("block_lat", lat, 8);
`endif
        chk("block_stable", 32'(stable), 0);
        chk("block_bps", 32'(bp_s), 1);
        chk("block_bpr", 32'(bp_r), 0);
        chk("block_cnt", 32'(bp_cnt), 1);
        chk("block_dup", 32'(err_dup), 0);

        step();
        run(3'b100);
        chk("dup_lat", lat, 4);
        chk("dup_err", 32'(err_dup), 1);
        chk("dup_stable", 32'(stable), 0);
        chk("dup_cnt", 32'(bp_cnt), 0);

        step();
        run(3'b001);
        chk("inval_lat", lat, 2);
        chk("inval_stable", 32'(stable), 0);
        chk("inval_dup", 32'(err_dup), 0);
        chk("inval_cnt", 32'(bp_cnt), 0);

        step();
        m_in  = 3'b110;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        while (lat < 6) step();
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (3) begin
            step();
            chk("midrst_no_done", 32'(done), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(3'b110);
        chk("after_rst_stable", 32'(stable), 0);
        chk("after_rst_bps", 32'(bp_s), 1);
        chk("after_rst_bpr", 32'(bp_r), 0);
        chk("after_rst_cnt", 32'(bp_cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
